// File: rtl/nv_ram_rws_param.sv
// Lane-masked register-file RAM with optional read output stage, write-to-read bypass
// and a one-entry-per-cycle zero-fill sweep.
module nv_ram_rws_param #(
    parameter int DW      = 512,
    parameter int AW      = 5,
    parameter int NLANE   = 8,
    parameter int RD_PIPE = 0
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic             re,
    input  logic [AW-1:0]    ra,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [NLANE-1:0] wmask,
    input  logic [DW-1:0]    di,
    input  logic             clr_req,
    input  logic [31:0]      pwrbus_ram_pd,
    output logic [DW-1:0]    dout,
    output logic             dout_vld,
    output logic             clr_busy
);

    localparam int LW    = DW / NLANE;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_e;

    logic [DW-1:0] mem_r [DEPTH];
    clr_state_e    state_r;
    logic [AW-1:0] clr_cnt_r;
    logic          clr_busy_r;
    logic [DW-1:0] dout_r;
    logic          dout_vld_r;

    logic          rd_acc_s;
    logic          wr_acc_s;
    logic [DW-1:0] rd_data_s;
    logic          pwrbus_unused_s;

    assign rd_acc_s        = re & ~clr_busy_r;
    assign wr_acc_s        = we & ~clr_busy_r;
    assign pwrbus_unused_s = ^pwrbus_ram_pd;

    // Read data with per-lane forwarding of a same-cycle write to the same address
    always_comb begin
        rd_data_s = mem_r[ra];
        for (int l = 0; l < NLANE; l++) begin
            if (wr_acc_s && (wa == ra) && wmask[l]) begin
                rd_data_s[l*LW +: LW] = di[l*LW +: LW];
            end else begin
                rd_data_s[l*LW +: LW] = mem_r[ra][l*LW +: LW];
            end
        end
    end

    // Clear sweep FSM: busy is high for exactly DEPTH cycles, one entry zeroed per cycle
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state_r    <= ST_IDLE;
            clr_cnt_r  <= {AW{1'b0}};
            clr_busy_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clr_req) begin
                        state_r    <= ST_CLEAR;
                        clr_cnt_r  <= {AW{1'b0}};
                        clr_busy_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        clr_busy_r <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_cnt_r == AW'(DEPTH - 1)) begin
                        state_r    <= ST_IDLE;
                        clr_cnt_r  <= {AW{1'b0}};
                        clr_busy_r <= 1'b0;
                    end else begin
                        clr_cnt_r  <= clr_cnt_r + AW'(1);
                        clr_busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    clr_cnt_r  <= {AW{1'b0}};
                    clr_busy_r <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: not reset; the sweep owns the write port while busy
    always_ff @(posedge nvdla_core_clk) begin
        if (clr_busy_r) begin
            mem_r[clr_cnt_r] <= {DW{1'b0}};
        end else if (wr_acc_s) begin
            for (int l = 0; l < NLANE; l++) begin
                if (wmask[l]) begin
                    mem_r[wa][l*LW +: LW] <= di[l*LW +: LW];
                end
            end
        end
    end

    generate
        if (RD_PIPE == 0) begin : g_rd_direct
            // Single-stage read result register
            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    dout_r     <= {DW{1'b0}};
                    dout_vld_r <= 1'b0;
                end else begin
                    dout_vld_r <= rd_acc_s;
                    if (rd_acc_s) begin
                        dout_r <= rd_data_s;
                    end else begin
                        dout_r <= dout_r;
                    end
                end
            end
        end else begin : g_rd_piped
            logic [DW-1:0] s1_data_r;
            logic          s1_vld_r;

            // Two-stage read path; a result already in flight drains even if a clear starts
            always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
                if (!nvdla_core_rstn) begin
                    s1_data_r  <= {DW{1'b0}};
                    s1_vld_r   <= 1'b0;
                    dout_r     <= {DW{1'b0}};
                    dout_vld_r <= 1'b0;
                end else begin
                    s1_vld_r   <= rd_acc_s;
                    dout_vld_r <= s1_vld_r;
                    if (rd_acc_s) begin
                        s1_data_r <= rd_data_s;
                    end else begin
                        s1_data_r <= s1_data_r;
                    end
                    if (s1_vld_r) begin
                        dout_r <= s1_data_r;
                    end else begin
                        dout_r <= dout_r;
                    end
                end
            end
        end
    endgenerate

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign clr_busy = clr_busy_r;

endmodule

// File: doc/nv_ram_rws_param.md
NV_RAM_RWS_PARAM -- requirements
Module: nv_ram_rws_param

Interface
REQ-001 Parameter DW, default 512: data width in bits.
REQ-002 Parameter AW, default 5: address width; DEPTH = 2**AW entries, addresses 0..DEPTH-1.
REQ-003 Parameter NLANE, default 8: write-mask lanes; DW SHALL be a multiple of NLANE; lane width LW = DW/NLANE.
REQ-004 Parameter RD_PIPE, default 0: 0 gives 1-cycle read latency, 1 adds an output register stage for 2-cycle latency.
REQ-005 nvdla_core_clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 nvdla_core_rstn  input  1  asynchronous active-low reset.
REQ-007 re  input  1  read enable.
REQ-008 ra  input  AW  read address.
REQ-009 we  input  1  write enable.
REQ-010 wa  input  AW  write address.
REQ-011 wmask  input  NLANE  per-lane write enable; lane l covers di[l*LW +: LW].
REQ-012 di  input  DW  write data.
REQ-013 clr_req  input  1  single-cycle pulse requesting a zero-fill of the whole array.
REQ-014 pwrbus_ram_pd  input  32  power-control bus; no functional effect.
REQ-015 dout  output  DW  read data.
REQ-016 dout_vld  output  1  high for exactly one cycle when dout carries a new read result.
REQ-017 clr_busy  output  1  high while a clear sweep is in progress.

Function
REQ-018 A write occurs when we=1 and clr_busy=0: each lane l with wmask[l]=1 is updated at wa; lanes with wmask[l]=0 keep their value.
REQ-019 A read is accepted when re=1 and clr_busy=0; the array is sampled at ra in the accepting cycle.
REQ-020 RD_PIPE=0: the result appears on dout with dout_vld=1 in the cycle after acceptance.
REQ-021 RD_PIPE=1: the result appears on dout with dout_vld=1 two cycles after acceptance; back-to-back reads give one result per cycle.
REQ-022 Same-cycle read and write to the same address (re, we, ra==wa, not busy): per lane, the result is di when wmask[l]=1, otherwise the old array value.
REQ-023 A write in a later cycle than the read's acceptance has no effect on that read's result.
REQ-024 dout holds its last value when no new result is presented; dout_vld is 0 in those cycles.
REQ-025 Clear FSM states: IDLE and CLEAR.
REQ-026 IDLE -> CLEAR on clr_req=1; the clear counter loads 0 and clr_busy rises in the next cycle.
REQ-027 In CLEAR, one entry per cycle (counter value) is written with all-zero data on all lanes, and the counter increments.
REQ-028 CLEAR -> IDLE after entry DEPTH-1 is written; clr_busy is high for exactly DEPTH cycles.
REQ-029 While clr_busy=1: re, we and clr_req are ignored, and no dout_vld is generated for those cycles.
REQ-030 A read accepted in the cycle clr_req arrives completes normally; a same-cycle write is also performed.
REQ-031 With RD_PIPE=1, a read already in the output stage when clear starts still completes.
REQ-032 Address counters and addresses wrap modulo DEPTH; no out-of-range access is possible.

Reset
REQ-033 While nvdla_core_rstn=0: dout=0, dout_vld=0, clr_busy=0, FSM=IDLE, clear counter=0, pipeline stage cleared; array contents are not reset.
REQ-034 Reset asserted mid-clear aborts the sweep; array contents are then unspecified until rewritten or cleared.
REQ-035 The first operation is accepted in the first rising edge after nvdla_core_rstn rises.

Verification
REQ-036 RD_PIPE=0: write 0xA5-pattern at addr 3 with wmask all-ones, then re at ra=3 -> dout=pattern, dout_vld=1 exactly one cycle after re.
REQ-037 Partial write: addr 7 holds all-ones; write di=0 with wmask=8'b0000_0001 -> a later read returns all-ones except lane 0 = 0.
REQ-038 Bypass: same cycle re=we=1, ra=wa=9, wmask=8'b1111_0000 -> upper 4 lanes = di, lower 4 lanes = prior contents, next cycle.
REQ-039 RD_PIPE=1: reads on 4 consecutive cycles -> 4 consecutive dout_vld pulses starting 2 cycles after the first read, in order.
REQ-040 Fill all entries, pulse clr_req -> clr_busy high exactly DEPTH cycles; a re/we during busy gives no dout_vld and no write; all subsequent reads return 0.
REQ-041 Assert reset at clear count DEPTH/2 -> clr_busy=0 and dout_vld=0 immediately; after release, a write then a read to addr 0 returns the written data.
